// File: rtl/fifo_ctrl_flags.sv
// fifo_ctrl_flags: pointer, occupancy and status-flag controller for a
// 2**ADDR_W-entry dual-port RAM with a synchronous write port and a
// registered read port.
//
// The controller only issues addresses and strobes. The RAM presents read
// data one cycle after rd_en, and this block adds no further latency.
// All flags are decoded combinationally from the count register, so they
// reflect the state produced by the most recent clock edge.
module fifo_ctrl_flags #(
  parameter int ADDR_W    = 4,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic              read,
  input  logic              flush,
  input  logic              clr_err,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [ADDR_W-1:0] readAddr,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
);

  // Count-width constants, so that every flag compare is width-matched.
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF_LVL    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_LVL    = (ADDR_W+1)'(AE_THRESH);
  localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push_ok;
  logic              pop_ok;
  logic              ovf_set;
  logic              udf_set;

  // Accept decisions and error detection for the current cycle.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave a value held and infer a latch.
  always_comb begin
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    ovf_set = 1'b0;
    udf_set = 1'b0;
    // When the FIFO is full, a push is still accepted if a pop frees a slot
    // in the same cycle.
    push_ok = write & (~full | read);
    pop_ok  = read & ~empty;
    // A flush swallows any concurrent request, so a rejected request during
    // a flush does not raise an error.
    ovf_set = write & ~push_ok & ~flush;
    udf_set = read  & ~pop_ok  & ~flush;
  end

  // RAM strobes are suppressed during a flush, so the RAM never sees an
  // access that the pointers will not record.
  assign wr_en     = push_ok & ~flush;
  assign rd_en     = pop_ok  & ~flush;
  assign writeAddr = wr_ptr;
  assign readAddr  = rd_ptr;

  // Status flags decoded from the occupancy register.
  always_comb begin
    empty        = 1'b0;
    full         = 1'b0;
    almost_empty = 1'b0;
    almost_full  = 1'b0;
    empty        = (count == '0);
    full         = (count == DEPTH_CNT);
    almost_empty = (count <= AE_LVL);
    almost_full  = (count >= AF_LVL);
  end

  // Pointer and occupancy update. The pointers wrap naturally at ADDR_W bits.
  // NOTE: state registers use non-blocking assignments, so every register
  // samples the values from before the edge regardless of statement order.
  // NOTE: only control state is reset. The RAM contents are never cleared,
  // because count and the pointers alone decide which entries are valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags. A new error in the same cycle as clr_err wins, so
  // no event is ever lost. A flush leaves both flags unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (udf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl_flags.sv
// Bench for fifo_ctrl_flags (ADDR_W=4, AF=12, AE=2).
// The driver issues one request vector per cycle and pushes the expected
// strobes, addresses and post-edge state into a queue. The monitor pops one
// record per cycle and compares it against the DUT. Checkpoints computed by
// hand are also checked directly by the driver.
module tb_fifo_ctrl_flags;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  typedef struct {
    string      tag;
    logic       wr_en;
    logic       rd_en;
    logic [3:0] waddr;
    logic [3:0] raddr;
    logic [4:0] cnt;
    logic       empty;
    logic       full;
    logic       ae;
    logic       af;
    logic       ovf;
    logic       udf;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       write, read, flush, clr_err;
  logic       wr_en, rd_en;
  logic [3:0] writeAddr, readAddr;
  logic [4:0] count;
  logic       empty, full, almost_empty, almost_full, overflow, underflow;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t sb[$];

  // Reference state, kept as plain integers.
  int  m_wp, m_rp, m_cnt;
  bit  m_ovf, m_udf;

  fifo_ctrl_flags #(.ADDR_W(ADDR_W), .AF_THRESH(12), .AE_THRESH(2)) dut (
    .clk(clk), .reset(reset), .write(write), .read(read), .flush(flush),
    .clr_err(clr_err), .wr_en(wr_en), .rd_en(rd_en), .writeAddr(writeAddr),
    .readAddr(readAddr), .count(count), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_wp = 0; m_rp = 0; m_cnt = 0; m_ovf = 0; m_udf = 0;
  endtask

  // One cycle of stimulus. It returns 1 time unit after the edge, with the
  // inputs still applied.
  task automatic step(input bit w, input bit r, input bit f, input bit c, input string tag);
    exp_t e;
    bit acc_w, acc_r, is_full, is_empty;
    @(negedge clk);
    write = w; read = r; flush = f; clr_err = c;
    is_full  = (m_cnt == DEPTH);
    is_empty = (m_cnt == 0);
    acc_w = w && (!is_full || r);
    acc_r = r && !is_empty;
    e.tag   = tag;
    e.wr_en = acc_w && !f;
    e.rd_en = acc_r && !f;
    e.waddr = 4'(m_wp);
    e.raddr = 4'(m_rp);
    if (f) begin
      m_wp = 0; m_rp = 0; m_cnt = 0;
    end else begin
      m_wp  = (m_wp + int'(acc_w)) % DEPTH;
      m_rp  = (m_rp + int'(acc_r)) % DEPTH;
      m_cnt = m_cnt + int'(acc_w) - int'(acc_r);
    end
    if (w && !acc_w && !f) m_ovf = 1; else if (c) m_ovf = 0;
    if (r && !acc_r && !f) m_udf = 1; else if (c) m_udf = 0;
    e.cnt   = 5'(m_cnt);
    e.empty = (m_cnt == 0);
    e.full  = (m_cnt == DEPTH);
    e.ae    = (m_cnt <= 2);
    e.af    = (m_cnt >= 12);
    e.ovf   = m_ovf;
    e.udf   = m_udf;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  // Monitor: strobes and addresses are sampled mid-cycle, and state is
  // sampled just after the edge.
  initial begin
    exp_t e;
    logic s_wr, s_rd;
    logic [3:0] s_wa, s_ra;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        s_wr = wr_en; s_rd = rd_en; s_wa = writeAddr; s_ra = readAddr;
        @(posedge clk);
        #1;
        check({e.tag, ".wr_en"},     32'(s_wr),         32'(e.wr_en));
        check({e.tag, ".rd_en"},     32'(s_rd),         32'(e.rd_en));
        check({e.tag, ".writeAddr"}, 32'(s_wa),         32'(e.waddr));
        check({e.tag, ".readAddr"},  32'(s_ra),         32'(e.raddr));
        check({e.tag, ".count"},     32'(count),        32'(e.cnt));
        check({e.tag, ".empty"},     32'(empty),        32'(e.empty));
        check({e.tag, ".full"},      32'(full),         32'(e.full));
        check({e.tag, ".almost_empty"}, 32'(almost_empty), 32'(e.ae));
        check({e.tag, ".almost_full"},  32'(almost_full),  32'(e.af));
        check({e.tag, ".overflow"},  32'(overflow),     32'(e.ovf));
        check({e.tag, ".underflow"}, 32'(underflow),    32'(e.udf));
      end
    end
  end

  // Hand-computed checkpoint of the registered state.
  task automatic expect_state(input string name, input int cnt, input int wa, input int ra,
                              input bit ovf, input bit udf);
    check({name, ".count"},     32'(count),     32'(cnt));
    check({name, ".writeAddr"}, 32'(writeAddr), 32'(wa));
    check({name, ".readAddr"},  32'(readAddr),  32'(ra));
    check({name, ".overflow"},  32'(overflow),  32'(ovf));
    check({name, ".underflow"}, 32'(underflow), 32'(udf));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; write = 0; read = 0; flush = 0; clr_err = 0;
    model_reset();
    #3;
    check("rst.count", 32'(count), 32'd0);
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.almost_empty", 32'(almost_empty), 32'd1);
    check("rst.full", 32'(full), 32'd0);
    check("rst.almost_full", 32'(almost_full), 32'd0);
    check("rst.overflow", 32'(overflow), 32'd0);
    check("rst.underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: sixteen writes fill the FIFO. almost_full turns on at a count of 12.
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 0, "fill");
      check("fill.count", 32'(count), 32'(i + 1));
      check("fill.almost_full", 32'(almost_full), 32'((i + 1) >= 12));
      check("fill.full", 32'(full), 32'(i == 15));
    end

    // 2: a write while full is rejected, and overflow stays set until cleared.
    step(1, 0, 0, 0, "ovf");
    expect_state("ovf", 16, 0, 0, 1, 0);
    repeat (3) idle();
    check("ovf_hold.overflow", 32'(overflow), 32'd1);
    step(0, 0, 0, 1, "ovf_clr");
    check("ovf_clr.overflow", 32'(overflow), 32'd0);

    // 3: sixteen reads drain the FIFO, and a seventeenth read underflows.
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, "drain");
      check("drain.count", 32'(count), 32'(15 - i));
      check("drain.empty", 32'(empty), 32'(i == 15));
      check("drain.almost_empty", 32'(almost_empty), 32'((15 - i) <= 2));
    end
    step(0, 1, 0, 0, "udf");
    expect_state("udf", 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, "udf_clr");
    check("udf_clr.underflow", 32'(underflow), 32'd0);

    // 4: at a count of 5, twenty simultaneous read/write cycles wrap both pointers.
    repeat (5) step(1, 0, 0, 0, "pre5");
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 0, "rw5");
      check("rw5.count", 32'(count), 32'd5);
    end
    expect_state("rw5_end", 5, 9, 4, 0, 0);

    // 5: read/write together while full, then while empty.
    repeat (11) step(1, 0, 0, 0, "refill");
    check("refill.full", 32'(full), 32'd1);
    step(1, 1, 0, 0, "rw_full");
    check("rw_full.full", 32'(full), 32'd1);
    expect_state("rw_full", 16, 5, 5, 0, 0);
    repeat (16) step(0, 1, 0, 0, "redrain");
    step(1, 1, 0, 0, "rw_empty");
    expect_state("rw_empty", 1, 6, 5, 0, 1);
    // A clear together with a valid read clears the flag.
    step(0, 1, 0, 1, "clr_ok");
    check("clr_ok.underflow", 32'(underflow), 32'd0);
    // A clear together with a new underflow leaves the flag set.
    step(0, 1, 0, 1, "set_wins");
    check("set_wins.underflow", 32'(underflow), 32'd1);
    step(0, 0, 0, 1, "clr2");
    check("clr2.underflow", 32'(underflow), 32'd0);

    // 6: flush at a count of 9 with write asserted.
    repeat (9) step(1, 0, 0, 0, "to9");
    check("to9.count", 32'(count), 32'd9);
    step(1, 0, 1, 0, "flush_w");
    expect_state("flush_w", 0, 0, 0, 0, 0);
    check("flush_w.empty", 32'(empty), 32'd1);
    step(0, 1, 1, 0, "flush_r");
    check("flush_r.underflow", 32'(underflow), 32'd0);

    // Asynchronous reset in the middle of a burst, with an error flag set.
    step(0, 1, 0, 0, "pre_rst_udf");
    repeat (3) step(1, 0, 0, 0, "burst");
    check("burst.count", 32'(count), 32'd3);
    @(negedge clk);
    write = 1;
    #2;
    reset = 1'b1;
    #1;
    check("async_rst.count", 32'(count), 32'd0);
    check("async_rst.empty", 32'(empty), 32'd1);
    check("async_rst.almost_empty", 32'(almost_empty), 32'd1);
    check("async_rst.writeAddr", 32'(writeAddr), 32'd0);
    check("async_rst.readAddr", 32'(readAddr), 32'd0);
    check("async_rst.underflow", 32'(underflow), 32'd1 - 32'd1);
    @(negedge clk);
    write = 0;
    reset = 1'b0;
    model_reset();
    step(1, 0, 0, 0, "post_rst");
    expect_state("post_rst", 1, 1, 0, 0, 0);

    // Let the monitor drain the queue, within a bounded number of cycles.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
